// File: rtl/eot_framer_if.sv
// Valid/ready stream bundle used by the eot framer for command, payload and framed output.
// master drives valid/data, slave drives ready.
interface eot_framer_if #(
  parameter int unsigned W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/eot_framer.sv
// Frames a raw beat stream into LEN-beat frames, flagging the last beat with eot in bit DIN.
// Optional 16-bit completed-frame counter enabled by defining EOT_FRAMER_FRMCNT_EN.
module eot_framer #(
  parameter int unsigned DIN  = 16,
  parameter int unsigned LENW = 10
) (
  input  logic          clk,
  input  logic          rst,
  eot_framer_if.slave   cfg,
  eot_framer_if.slave   din,
  eot_framer_if.master  dout
`ifdef EOT_FRAMER_FRMCNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic            vld_q, vld_d;
  logic [DIN:0]    data_q, data_d;

  logic out_ready;
  logic cfg_hs;
  logic din_hs;
  logic last_beat;

  assign out_ready = !vld_q || dout.ready;
  assign last_beat = (cnt_q == (len_q - LENW'(1)));

  // Readies are gated by rst so both read 0 while reset is held.
  assign cfg.ready = !rst && (state_q == StIdle);
  assign din.ready = !rst && (state_q == StRun) && out_ready;

  assign cfg_hs = cfg.valid && cfg.ready;
  assign din_hs = din.valid && din.ready;

  assign dout.valid = vld_q;
  assign dout.data  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    vld_d   = vld_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (out_ready) vld_d = 1'b0;
        // Zero-length commands are consumed and dropped.
        if (cfg_hs && (cfg.data != '0)) begin
          len_d   = cfg.data;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (din_hs) begin
          data_d = {last_beat, din.data};
          vld_d  = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + LENW'(1);
          end
        end else if (out_ready) begin
          vld_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

`ifdef EOT_FRAMER_FRMCNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vld_q && dout.ready && data_q[DIN]) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_eot_framer.sv
// Directed bench for eot_framer: vector table for basic/backpressure/zero-length frames,
// plus sequences for max length, async reset mid-frame and the optional frame counter.
module tb_eot_framer;

  localparam int unsigned DIN  = 16;
  localparam int unsigned LENW = 4;

  logic clk;
  logic rst;

  eot_framer_if #(.W(LENW))  cfg_if ();
  eot_framer_if #(.W(DIN))   din_if ();
  eot_framer_if #(.W(DIN+1)) dout_if ();

`ifdef EOT_FRAMER_FRMCNT_EN
  logic [15:0] frame_cnt;
`endif

  eot_framer #(
    .DIN  (DIN),
    .LENW (LENW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .din       (din_if),
    .dout      (dout_if)
`ifdef EOT_FRAMER_FRMCNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic            cv;
    logic [LENW-1:0] cd;
    logic            dv;
    logic [DIN-1:0]  dd;
    logic            rdy;
    logic            ecr;
    logic            edr;
    logic            eov;
    logic [DIN:0]    eod;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [LENW-1:0] cd, input logic dv,
                              input logic [DIN-1:0] dd, input logic rdy, input logic ecr,
                              input logic edr, input logic eov, input logic [DIN:0] eod);
    vec_t v;
    v.cv = cv; v.cd = cd; v.dv = dv; v.dd = dd; v.rdy = rdy;
    v.ecr = ecr; v.edr = edr; v.eov = eov; v.eod = eod;
    return v;
  endfunction

  vec_t vecs [22];

  // One frame with dout.ready held high; len 0 exercises the dropped command.
  task automatic do_frame(input int len, input logic [DIN-1:0] base);
    @(negedge clk);
    cfg_if.valid = 1'b1;
    cfg_if.data  = LENW'(len);
    din_if.valid = 1'b0;
    dout_if.ready = 1'b1;
    #1 chk("frame_cfg_ready", 32'(cfg_if.ready), 32'd1);
    @(negedge clk);
    cfg_if.valid = 1'b0;
    if (len == 0) begin
      #1 chk("zero_len_idle", 32'(cfg_if.ready), 32'd1);
      chk("zero_len_no_out", 32'(dout_if.valid), 32'd0);
    end else begin
      for (int i = 0; i < len; i++) begin
        din_if.valid = 1'b1;
        din_if.data  = base + DIN'(i);
        #1 chk("frame_din_ready", 32'(din_if.ready), 32'd1);
        if (i > 0) begin
          chk("frame_beat_valid", 32'(dout_if.valid), 32'd1);
          chk("frame_beat_data", 32'(dout_if.data), 32'({1'b0, base + DIN'(i - 1)}));
        end
        @(negedge clk);
      end
      din_if.valid = 1'b0;
      #1 chk("frame_last_valid", 32'(dout_if.valid), 32'd1);
      chk("frame_last_data", 32'(dout_if.data), 32'({1'b1, base + DIN'(len - 1)}));
      chk("frame_back_idle", 32'(cfg_if.ready), 32'd1);
      chk("frame_idle_din_ready", 32'(din_if.ready), 32'd0);
      exp_fc++;
      @(negedge clk);
      #1 chk("frame_drained", 32'(dout_if.valid), 32'd0);
    end
`ifdef EOT_FRAMER_FRMCNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
`endif
  endtask

  initial begin
    rst = 1'b1;
    cfg_if.valid = 1'b0; cfg_if.data = '0;
    din_if.valid = 1'b0; din_if.data = '0;
    dout_if.ready = 1'b1;

    //                cv cd     dv dd        rdy ecr edr eov eod
    vecs[0]  = mk(1, 4'd3, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);
    vecs[1]  = mk(0, 4'd0, 1, 16'h00A1, 1, 0, 1, 0, 17'h00000);
    vecs[2]  = mk(0, 4'd0, 1, 16'h00A2, 1, 0, 1, 1, 17'h000A1);
    vecs[3]  = mk(0, 4'd0, 1, 16'h00A3, 1, 0, 1, 1, 17'h000A2);
    vecs[4]  = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 1, 17'h100A3);
    vecs[5]  = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);
    vecs[6]  = mk(1, 4'd4, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);
    vecs[7]  = mk(0, 4'd0, 1, 16'h00B1, 1, 0, 1, 0, 17'h00000);
    vecs[8]  = mk(0, 4'd0, 1, 16'h00B2, 0, 0, 0, 1, 17'h000B1);
    vecs[9]  = mk(0, 4'd0, 1, 16'h00B2, 0, 0, 0, 1, 17'h000B1);
    vecs[10] = mk(0, 4'd0, 1, 16'h00B2, 1, 0, 1, 1, 17'h000B1);
    vecs[11] = mk(0, 4'd0, 1, 16'h00B3, 0, 0, 0, 1, 17'h000B2);
    vecs[12] = mk(0, 4'd0, 1, 16'h00B3, 1, 0, 1, 1, 17'h000B2);
    vecs[13] = mk(0, 4'd0, 1, 16'h00B4, 1, 0, 1, 1, 17'h000B3);
    vecs[14] = mk(0, 4'd0, 0, 16'h0000, 0, 1, 0, 1, 17'h100B4);
    vecs[15] = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 1, 17'h100B4);
    vecs[16] = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);
    vecs[17] = mk(1, 4'd0, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);
    vecs[18] = mk(1, 4'd1, 1, 16'h0055, 1, 1, 0, 0, 17'h00000);
    vecs[19] = mk(0, 4'd0, 1, 16'h0055, 1, 0, 1, 0, 17'h00000);
    vecs[20] = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 1, 17'h10055);
    vecs[21] = mk(0, 4'd0, 0, 16'h0000, 1, 1, 0, 0, 17'h00000);

    #1;
    chk("rst_dout_valid", 32'(dout_if.valid), 32'd0);
    chk("rst_dout_data", 32'(dout_if.data), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_if.ready), 32'd0);
    chk("rst_din_ready", 32'(din_if.ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      cfg_if.valid  = vecs[i].cv;
      cfg_if.data   = vecs[i].cd;
      din_if.valid  = vecs[i].dv;
      din_if.data   = vecs[i].dd;
      dout_if.ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_if.ready), 32'(vecs[i].ecr));
      chk($sformatf("vec%0d_din_ready", i), 32'(din_if.ready), 32'(vecs[i].edr));
      chk($sformatf("vec%0d_dout_valid", i), 32'(dout_if.valid), 32'(vecs[i].eov));
      if (vecs[i].eov)
        chk($sformatf("vec%0d_dout_data", i), 32'(dout_if.data), 32'(vecs[i].eod));
    end

    // Three eot frames completed by the table above.
    exp_fc = 3;
`ifdef EOT_FRAMER_FRMCNT_EN
    chk("frame_cnt_after_vecs", 32'(frame_cnt), 32'(exp_fc));
`endif

    // Maximum length frame: 15 beats, eot only on the last.
    do_frame(15, 16'h0200);

    // Async reset mid-frame.
    @(negedge clk);
    cfg_if.valid = 1'b1; cfg_if.data = 4'd5;
    @(negedge clk);
    cfg_if.valid = 1'b0;
    din_if.valid = 1'b1; din_if.data = 16'h00D1;
    @(negedge clk);
    din_if.data = 16'h00D2;
    @(negedge clk);
    din_if.valid = 1'b0;
    #1 chk("pre_rst_valid", 32'(dout_if.valid), 32'd1);
    chk("pre_rst_data", 32'(dout_if.data), 32'h000D2);
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", 32'(dout_if.valid), 32'd0);
    chk("async_rst_data", 32'(dout_if.data), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_if.ready), 32'd0);
    chk("async_rst_din_ready", 32'(din_if.ready), 32'd0);
    #1 rst = 1'b0;
    #1 chk("post_rst_cfg_ready", 32'(cfg_if.ready), 32'd1);
    chk("post_rst_valid", 32'(dout_if.valid), 32'd0);
    exp_fc = 0;
`ifdef EOT_FRAMER_FRMCNT_EN
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    do_frame(2, 16'h00C1);

    // Frame counter sequence from a clean reset: lengths 1,2,0,3.
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_fc = 0;
    do_frame(1, 16'h0301);
    do_frame(2, 16'h0311);
    do_frame(0, 16'h0000);
    do_frame(3, 16'h0321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
